// File: rtl/axi_lite_vga_cfg_pkg.sv
// rtl/axi_lite_vga_cfg_pkg.sv - shared types and constants for the VGA config register file
package axi_lite_vga_cfg_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  localparam int CTRL_IDX        = 0;
  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_IRQ_BIT    = 1;

  typedef enum logic [1:0] {
    W_IDLE,
    W_EXEC,
    W_RESP
  } wstate_t;

endpackage

// File: rtl/axi_lite_vga_cfg_strb_merge.sv
// rtl/axi_lite_vga_cfg_strb_merge.sv - per-byte merge of old and new word under a write strobe
module axi_lite_vga_cfg_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_i,
  input  logic [DATA_WIDTH-1:0]   new_i,
  input  logic [DATA_WIDTH/8-1:0] strb_i,
  output logic [DATA_WIDTH-1:0]   merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (strb_i[b]) merged_o[b*8 +: 8] = new_i[b*8 +: 8];
    end
  end

endmodule

// File: rtl/axi_lite_vga_cfg_regs.sv
// rtl/axi_lite_vga_cfg_regs.sv - AXI4-Lite shadow/active VGA config registers, frame-synchronous commit
// Optional irq output and CTRL bit1 are enabled by VGA_CFG_REGS_IRQ_EN.
module axi_lite_vga_cfg_regs
  import axi_lite_vga_cfg_pkg::*;
#(
  parameter int                NUM_REGS    = 8,
  parameter int                DATA_WIDTH  = 32,
  parameter int                ADDR_WIDTH  = 10,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = 32'h0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  input  logic                           frame_start,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_active,
`ifdef VGA_CFG_REGS_IRQ_EN
  output logic                           irq,
`endif
  output logic                           commit_pending
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;

  wstate_t                      wstate_q, wstate_d;
  logic                         aw_full_q, w_full_q;
  logic [IDX_W-1:0]             aw_idx_q;
  logic [DATA_WIDTH-1:0]        w_data_q;
  logic [STRB_W-1:0]            w_strb_q;
  resp_t                        bresp_q, rresp_q;
  logic                         rvalid_q;
  logic [DATA_WIDTH-1:0]        rdata_q;
  logic [DATA_WIDTH-1:0]        shadow_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]        shadow_d [NUM_REGS];
  logic [NUM_REGS*DATA_WIDTH-1:0] cfg_active_q, cfg_active_d;
  logic                         pending_q, pending_d;
  logic                         aw_hs, w_hs, exec, apply;
  logic                         wr_is_ctrl, wr_in_range, rd_in_range;
  logic [IDX_W-1:0]             rd_idx;
  logic [DATA_WIDTH-1:0]        ctrl_rd, wr_old, wr_merged, rd_word;
`ifdef VGA_CFG_REGS_IRQ_EN
  logic                         irq_q, irq_d;
`endif
  logic                         unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign exec  = (wstate_q == W_EXEC);

  always_ff @(posedge ACLK) begin
    if (ARESET) wstate_q <= W_IDLE;
    else        wstate_q <= wstate_d;
  end

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE: if ((aw_full_q | aw_hs) & (w_full_q | w_hs)) wstate_d = W_EXEC;
      W_EXEC: wstate_d = W_RESP;
      W_RESP: if (S_AXI_BREADY) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // Ready is masked during reset so nothing can be accepted into a state being cleared.
  always_comb begin
    S_AXI_AWREADY = (wstate_q == W_IDLE) & ~aw_full_q & ~ARESET;
    S_AXI_WREADY  = (wstate_q == W_IDLE) & ~w_full_q & ~ARESET;
    S_AXI_BVALID  = (wstate_q == W_RESP);
  end

  assign S_AXI_BRESP = bresp_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= OKAY;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (exec) bresp_q <= wr_in_range ? OKAY : SLVERR;
      if (S_AXI_BVALID & S_AXI_BREADY) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_COMMIT_BIT] = pending_q;
`ifdef VGA_CFG_REGS_IRQ_EN
    ctrl_rd[CTRL_IRQ_BIT] = irq_q;
`endif
  end

  assign wr_is_ctrl  = (aw_idx_q == IDX_W'(CTRL_IDX));
  assign wr_in_range = (32'(aw_idx_q) <= NUM_REGS);

  always_comb begin
    wr_old = '0;
    if (wr_is_ctrl) wr_old = ctrl_rd;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (aw_idx_q == IDX_W'(k + 1)) wr_old = shadow_q[k];
    end
  end

  axi_lite_vga_cfg_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_i    (wr_old),
    .new_i    (w_data_q),
    .strb_i   (w_strb_q),
    .merged_o (wr_merged)
  );

  assign apply = frame_start & pending_q;

  // Commit copies pre-write shadow values; a same-cycle COMMIT write re-arms pending.
  always_comb begin
    shadow_d     = shadow_q;
    cfg_active_d = cfg_active_q;
    pending_d    = pending_q;
`ifdef VGA_CFG_REGS_IRQ_EN
    irq_d        = irq_q;
`endif
    if (apply) begin
      for (int k = 0; k < NUM_REGS; k++) cfg_active_d[k*DATA_WIDTH +: DATA_WIDTH] = shadow_q[k];
      pending_d = 1'b0;
    end
    if (exec && wr_in_range) begin
      if (wr_is_ctrl) begin
        if (w_strb_q[0] && wr_merged[CTRL_COMMIT_BIT]) pending_d = 1'b1;
`ifdef VGA_CFG_REGS_IRQ_EN
        if (w_strb_q[0] && wr_merged[CTRL_IRQ_BIT]) irq_d = 1'b0;
`endif
      end
      for (int k = 0; k < NUM_REGS; k++) begin
        if (aw_idx_q == IDX_W'(k + 1)) shadow_d[k] = wr_merged;
      end
    end
`ifdef VGA_CFG_REGS_IRQ_EN
    if (apply) irq_d = 1'b1;
`endif
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int k = 0; k < NUM_REGS; k++) shadow_q[k] <= RESET_VALUE;
      cfg_active_q <= {NUM_REGS{RESET_VALUE}};
      pending_q    <= 1'b0;
`ifdef VGA_CFG_REGS_IRQ_EN
      irq_q        <= 1'b0;
`endif
    end else begin
      shadow_q     <= shadow_d;
      cfg_active_q <= cfg_active_d;
      pending_q    <= pending_d;
`ifdef VGA_CFG_REGS_IRQ_EN
      irq_q        <= irq_d;
`endif
    end
  end

  assign cfg_active     = cfg_active_q;
  assign commit_pending = pending_q;
`ifdef VGA_CFG_REGS_IRQ_EN
  assign irq            = irq_q;
`endif

  assign rd_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:2];
  assign rd_in_range = (32'(rd_idx) <= NUM_REGS);

  always_comb begin
    rd_word = '0;
    if (rd_idx == IDX_W'(CTRL_IDX)) rd_word = ctrl_rd;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_idx == IDX_W'(k + 1)) rd_word = shadow_q[k];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_in_range ? rd_word : '0;
      rresp_q  <= rd_in_range ? OKAY : SLVERR;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_ARREADY = ~rvalid_q & ~ARESET;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: doc/axi_lite_vga_cfg_regs.md
Name: axi_lite_vga_cfg_regs

Overview:
- Parametrised AXI4-Lite slave register file for the Zybo VGA reconfigurable IP; successor to the fixed 4-register S00_AXI slave.
- Holds NUM_REGS software-visible shadow config registers plus one control register.
- Shadow values are copied into the active config bus, which feeds the VGA timing/pixel logic, only at a frame boundary after software requests a commit. This prevents mid-frame tearing.

Parameters:
- NUM_REGS, 8: number of shadow config registers (1..255).
- DATA_WIDTH, 32: AXI data width; only 32 is supported, fixed for byte-strobe math.
- ADDR_WIDTH, 10: AXI address width; must satisfy 2^(ADDR_WIDTH-2) >= NUM_REGS+1.
- RESET_VALUE, 32'h0: reset value of every shadow and active register.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous reset, active-high.
- S_AXI_AWADDR  in  ADDR_WIDTH; S_AXI_AWPROT in 3 (ignored); S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
- S_AXI_WDATA  in  DATA_WIDTH; S_AXI_WSTRB in DATA_WIDTH/8; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
- S_AXI_BRESP  out  2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
- S_AXI_ARADDR  in  ADDR_WIDTH; S_AXI_ARPROT in 3 (ignored); S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
- S_AXI_RDATA  out  DATA_WIDTH; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
- frame_start  in  1  one-cycle pulse from VGA timing at start of vertical blanking.
- cfg_active  out  NUM_REGS*DATA_WIDTH  active config; register k occupies bits [k*32+31:k*32].
- commit_pending  out  1  commit requested, not yet applied.

Behaviour:
- Reset (ARESET=1 at ACLK edge): all READY/VALID outputs 0, BRESP/RRESP=0, RDATA=0, shadow and cfg_active=RESET_VALUE, commit_pending=0. A transaction in flight is abandoned and no response is issued.
- Address map: word index = ADDR[ADDR_WIDTH-1:2], ADDR[1:0] ignored.
  - Index 0 is CTRL: bit0 COMMIT (write 1 sets pending; reads return commit_pending); other bits read 0.
  - Index 1..NUM_REGS maps to shadow[index-1].
  - Index > NUM_REGS is out of range: SLVERR (2'b10), write discarded, read data 0.
- Write FSM states:
  - W_IDLE: AWREADY=WREADY=1. AW and W are captured independently; a captured channel's READY drops until the response completes.
  - When both AW and W are held, the write executes next cycle with per-byte WSTRB. The state goes to W_RESP with BVALID=1 and BRESP=OKAY or SLVERR.
  - W_RESP: hold BVALID until BREADY, then return to W_IDLE. Ready returns the cycle after the handshake.
  - Minimum throughput is one write per 3 cycles.
- Read path:
  - ARREADY=1 when RVALID=0.
  - On AR handshake, RDATA/RRESP are registered and RVALID=1 the next cycle (latency 1).
  - Hold until RREADY, then ARREADY returns the following cycle.
  - Shadow registers are read back; active copies are not readable.
- Read and write channels are fully independent; a simultaneous read and write to the same register returns the pre-write value.
- Commit:
  - CTRL write with WSTRB[0]=1 and WDATA[0]=1 sets commit_pending.
  - On a frame_start cycle with commit_pending=1: cfg_active <= shadow (pre-write values of that cycle), and commit_pending clears.
  - A CTRL commit write in the same cycle as frame_start sets pending; it is applied at the next frame_start.
  - frame_start without pending: no change.
- Repeated COMMIT writes while pending: idempotent.

Optional Feature:
- Macro VGA_CFG_REGS_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, reset 0), set the cycle after a commit is applied.
  - CTRL bit1 reads irq and is write-1-to-clear.
  - A set in the same cycle as a clear wins (irq stays 1).
- Undefined: no irq port; CTRL bit1 reads 0 and writes are ignored.

Decomposition:
- Package axi_lite_vga_cfg_pkg holds:
  - resp_t enum: OKAY=2'b00, SLVERR=2'b10.
  - CTRL_IDX=0, CTRL_COMMIT_BIT=0, CTRL_IRQ_BIT=1.
  - Write FSM state enum {W_IDLE, W_EXEC, W_RESP}.
- One sub-module, axi_lite_vga_cfg_strb_merge: combinational per-byte merge of old/new word by WSTRB, reused for shadow and CTRL.

Test Plan:
- Reset then read all indices 0..NUM_REGS -> RDATA=0, RRESP=OKAY; cfg_active=0.
- Write shadow[2]=32'hA5A5_1234 (WSTRB=4'hF), then WSTRB=4'b0010 data 32'h0000_FF00 -> readback 32'hA5A5_FF34, cfg_active unchanged.
- Write CTRL=1, then pulse frame_start -> commit_pending 1->0, cfg_active reg2=32'hA5A5_FF34. A second frame_start leaves it unchanged.
- Issue W three cycles before AW, and hold BREADY low for 5 cycles -> single write, BVALID held, AWREADY/WREADY low until the B handshake.
- Write/read index NUM_REGS+1 -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, no register changes.
- CTRL commit write coincident with frame_start, then assert ARESET with commit_pending=1 -> commit not applied that frame, and reset clears pending and cfg_active. With VGA_CFG_REGS_IRQ_EN, irq=1 after an applied commit and 0 after a write of 32'h2 to CTRL.
